// File: rtl/mod_n_sequencer.sv
// mod_n_sequencer: runs a MOD-N count register for a programmed number of wraps under start/busy/done
// Ports:
//    clk_i, reset_i (async, active-high)
//    start_i, num_wraps_i  : run request and wrap count, sampled in IDLE only
//    pause_i, abort_i      : run control levels; abort has priority over pause
//    count_o, wrap_o       : count value and one-cycle pulse after a MOD-1 -> 0 step
//    wraps_left_o          : remaining wraps in the current run
//    busy_o, paused_o, done_o : run status; done is a one-cycle completion pulse
module mod_n_sequencer #(
   parameter int MOD = 6,
   parameter int CW  = 3,
   parameter int WW  = 4
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          start_i,
   input  logic [WW-1:0] num_wraps_i,
   input  logic          pause_i,
   input  logic          abort_i,
   output logic [CW-1:0] count_o,
   output logic          wrap_o,
   output logic [WW-1:0] wraps_left_o,
   output logic          busy_o,
   output logic          paused_o,
   output logic          done_o
);
   typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;
   localparam logic [CW-1:0] LAST = CW'(MOD - 1);
   state_t        state_q;
   logic [CW-1:0] count_q;
   logic [WW-1:0] wraps_left_q;
   logic          wrap_q, busy_q, paused_q, done_q;
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= IDLE;
         count_q      <= '0;
         wraps_left_q <= '0;
         wrap_q       <= 1'b0;
         busy_q       <= 1'b0;
         paused_q     <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         wrap_q <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               count_q <= '0;
               if (start_i && num_wraps_i != '0) begin
                  state_q      <= RUN;
                  wraps_left_q <= num_wraps_i;
                  busy_q       <= 1'b1;
               end else if (start_i) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end
            end
            RUN, HOLD: begin
               if (abort_i) begin
                  state_q      <= IDLE;
                  count_q      <= '0;
                  wraps_left_q <= '0;
                  busy_q       <= 1'b0;
                  paused_q     <= 1'b0;
               end else if (pause_i) begin
                  state_q  <= HOLD;
                  paused_q <= 1'b1;
               end else begin
                  state_q  <= RUN;
                  paused_q <= 1'b0;
                  if (count_q == LAST) begin
                     count_q      <= '0;
                     wrap_q       <= 1'b1;
                     wraps_left_q <= wraps_left_q - 1'b1;
                     // the last wrap finishes the run; wrap and done share that cycle
                     if (wraps_left_q == WW'(1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                     end
                  end else begin
                     count_q <= count_q + 1'b1;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               count_q <= '0;
            end
         endcase
      end
   end
   assign count_o      = count_q;
   assign wrap_o       = wrap_q;
   assign wraps_left_o = wraps_left_q;
   assign busy_o       = busy_q;
   assign paused_o     = paused_q;
   assign done_o       = done_q;
endmodule

// File: doc/mod_n_sequencer.md
Name: mod_n_sequencer

Overview:
Run-control sequencer for the team's modulo-N counter datapath. It owns a MOD-N count register and runs it for a programmed number of full wrap-arounds under a start/busy/done handshake, with pause and abort. Upstream control logic uses it to time fixed-length phases, such as N×6-cycle frames with the default MOD=6.

Parameters:
MOD, 6, counter modulus; count sequence is 0..MOD-1; legal range 2..2^CW.
CW, 3, width of count output.
WW, 4, width of num_wraps / wraps_left.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request a run; sampled only in IDLE
num_wraps  input  WW  number of full MOD cycles to run; captured on the accepted start
pause  input  1  level; freezes count while high during a run
abort  input  1  level; terminates a run without done
count  output  CW  current count value
wrap  output  1  one-cycle pulse, high in the cycle after count goes MOD-1 -> 0
wraps_left  output  WW  remaining wraps in the current run
busy  output  1  high in RUN and HOLD
paused  output  1  high in HOLD
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, immediate, no clock edge needed): state=IDLE; count=0, wrap=0, wraps_left=0, busy=0, paused=0, done=0. All outputs are registered.
- States: IDLE, RUN, HOLD, DONE.
- IDLE:
  - start=1 and num_wraps!=0 at edge E0 -> RUN; wraps_left=num_wraps; count=0; busy=1 after E0.
  - start=1 and num_wraps==0 -> DONE. No counting, no wrap, busy stays 0.
  - start=0 -> stay in IDLE; count holds 0.
- RUN/HOLD, per edge, priority abort > pause > advance:
  - abort=1 -> IDLE; count=0; wraps_left=0; busy=0; no done, no wrap.
  - pause=1 -> HOLD, or stay in HOLD; count and wraps_left frozen; wrap=0.
  - Otherwise -> RUN; count advances:
    - count<MOD-1 -> count+1.
    - count==MOD-1 -> count=0; wrap=1 for that one cycle; wraps_left-1.
    - If that wrap takes wraps_left from 1 to 0 -> DONE.
  - Dropping pause in HOLD resumes advancing on the same edge.
- DONE: done=1, busy=0, count=0, lasts exactly one cycle, then IDLE. The final wrap pulse and done are high in the same cycle.
- Latency: with no pause, done rises exactly num_wraps×MOD edges after E0. Each paused edge adds one cycle.
- start is ignored in RUN, HOLD and DONE. num_wraps changes after E0 are ignored.
- abort is ignored in IDLE and DONE. pause is ignored outside RUN/HOLD.
- Simultaneous abort with a final wrap: abort wins; no done.
- Reset mid-run: immediate return to the reset values; no done.
- Widths: count never exceeds MOD-1. wraps_left is unsigned and never underflows.

Test Plan:
- Assert reset asynchronously between edges while count=4, busy=1 -> all outputs 0 before the next clk edge; state IDLE after release.
- start with num_wraps=2, MOD=6 -> count 0,1..5,0,1..5,0; wrap high after edges E0+6 and E0+12; wraps_left 2->1->0; done high for one cycle after E0+12; busy high for 12 cycles.
- Run num_wraps=1; hold pause high for 3 edges while count=3 -> count stays 3, paused=1 for 3 cycles, busy stays 1; done arrives at E0+9.
- Run num_wraps=1; assert abort one cycle at count=4, together with pause -> next cycle IDLE, count=0, wraps_left=0, done never asserted.
- start with num_wraps=0 -> done pulse in the cycle after E0; busy, wrap and count stay 0.
- During a run, pulse start and change num_wraps to 7 -> ignored; run completes after the original length; wraps_left never reloads.
